// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC core.
// Also carries the arctangent table generator and the CORDIC gain.
package cordic_pkg;

  typedef enum logic {
    CORDIC_ROT = 1'b0,
    CORDIC_VEC = 1'b1
  } cordic_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cordic_state_e;

  localparam real CORDIC_K = 1.6467602581210656;

  // round(atan(2^-k) * 2^width), evaluated at elaboration only
  function automatic longint atan_lut(input int k, input int width);
    real t;
    real p;
    real s;
    if (k == 0) begin
      s = 0.78539816339744830962;
    end else begin
      t = 1.0 / (2.0 ** k);
      p = t;
      s = 0.0;
      for (int n = 0; n < 60; n++) begin
        if (n % 2 == 0) s = s + p / real'(2 * n + 1);
        else            s = s - p / real'(2 * n + 1);
        p = p * t * t;
      end
    end
    return longint'($rtoi(s * (2.0 ** width) + 0.5));
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// Single combinational CORDIC micro-rotation.
// Angle constants are built at elaboration and selected by k.
import cordic_pkg::*;

module cordic_stage #(
  parameter int WIDTH = 24,
  parameter int IW    = WIDTH + 2,
  parameter int KW    = 4
) (
  input  logic signed [IW-1:0] x,
  input  logic signed [IW-1:0] y,
  input  logic signed [IW-1:0] z,
  input  logic        [KW-1:0] k,
  input  cordic_mode_e         mode,
  output logic signed [IW-1:0] x_n,
  output logic signed [IW-1:0] y_n,
  output logic signed [IW-1:0] z_n
);

  logic signed [IW-1:0] atan_tab [2**KW];
  logic signed [IW-1:0] xs;
  logic signed [IW-1:0] ys;
  logic signed [IW-1:0] at;
  logic                 d_pos;

  for (genvar i = 0; i < 2**KW; i++) begin : g_atan
    localparam logic signed [IW-1:0] A = IW'(atan_lut(i, WIDTH));
    assign atan_tab[i] = A;
  end

  // zero counts as positive: z==0 -> d=+1, y==0 -> d=-1
  assign d_pos = (mode == CORDIC_ROT) ? ~z[IW-1] : y[IW-1];
  assign xs    = x >>> k;
  assign ys    = y >>> k;
  assign at    = atan_tab[k];

  always_comb begin
    x_n = x;
    y_n = y;
    z_n = z;
    if (d_pos) begin
      x_n = x - ys;
      y_n = y + xs;
      z_n = z - at;
    end else begin
      x_n = x + ys;
      y_n = y - xs;
      z_n = z + at;
    end
  end

endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC: one micro-rotation per clock on a shared stage,
// valid/ready handshakes on both sides, no gain compensation.
import cordic_pkg::*;

module cordic_iter #(
  parameter int WIDTH = 24,
  parameter int ITERS = 16,
  parameter int IW    = WIDTH + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [IW-1:0] z_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [IW-1:0] x_out,
  output logic signed [IW-1:0] y_out,
  output logic signed [IW-1:0] z_out
);

  localparam int KW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(ITERS - 1);

  cordic_state_e        state_q;
  cordic_state_e        state_d;
  cordic_mode_e         mode_q;
  logic        [KW-1:0] k_q;
  logic signed [IW-1:0] x_q;
  logic signed [IW-1:0] y_q;
  logic signed [IW-1:0] z_q;
  logic signed [IW-1:0] x_n;
  logic signed [IW-1:0] y_n;
  logic signed [IW-1:0] z_n;
  logic                 accept;

  cordic_stage #(
    .WIDTH (WIDTH),
    .IW    (IW),
    .KW    (KW)
  ) u_stage (
    .x    (x_q),
    .y    (y_q),
    .z    (z_q),
    .k    (k_q),
    .mode (mode_q),
    .x_n  (x_n),
    .y_n  (y_n),
    .z_n  (z_n)
  );

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == IDLE: if (in_valid)        state_d = RUN;
      state_q == RUN:  if (k_q == K_LAST)   state_d = DONE;
      state_q == DONE: if (out_ready)       state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  // in_ready is gated by rst_n so it stays low while reset is held
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      state_q == IDLE: in_ready  = rst_n;
      state_q == DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= CORDIC_ROT;
      k_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
    end else if (accept) begin
      mode_q <= cordic_mode_e'(mode);
      k_q    <= '0;
      x_q    <= {{(IW-WIDTH){x_in[WIDTH-1]}}, x_in};
      y_q    <= {{(IW-WIDTH){y_in[WIDTH-1]}}, y_in};
      z_q    <= z_in;
    end else if (state_q == RUN) begin
      k_q    <= k_q + 1'b1;
      x_q    <= x_n;
      y_q    <= y_n;
      z_q    <= z_n;
    end
  end

  assign x_out = x_q;
  assign y_out = y_q;
  assign z_out = z_q;

endmodule

// File: tb/tb_cordic_iter.sv
// Directed self-checking bench for cordic_iter (WIDTH=16, ITERS=16).
// Expected results are hand-derived K-scaled values with +/-16 LSB slack.
module tb_cordic_iter;

  localparam int WIDTH = 16;
  localparam int ITERS = 16;
  localparam int IW    = WIDTH + 2;
  localparam int TOL   = 16;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic                    mode;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic signed [IW-1:0]    z_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [IW-1:0]    x_out;
  logic signed [IW-1:0]    y_out;
  logic signed [IW-1:0]    z_out;

  int n_checks = 0;
  int n_fail   = 0;

  cordic_iter #(
    .WIDTH (WIDTH),
    .ITERS (ITERS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int adiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic start_op(input logic m, input int x, input int y,
                          input int z, output bit ok);
    int n;
    @(negedge clk);
    mode     = m;
    x_in     = WIDTH'(x);
    y_in     = WIDTH'(y);
    z_in     = IW'(z);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b want 0 0",
               in_ready, out_valid);
    end
    n_checks++;
    if (x_out !== 0 || y_out !== 0 || z_out !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: x=%0d y=%0d z=%0d want 0 0 0",
               x_out, y_out, z_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic run_scenario(input string nm, input logic m,
                              input int x, input int y, input int z,
                              input int ex, input int ey, input int ez);
    bit ok;
    int lat;
    start_op(m, x, y, z, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_accept: in_ready never rose", nm);
    end
    wait_done(lat);
    n_checks++;
    if (lat !== ITERS) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d want %0d", nm, lat, ITERS);
    end
    n_checks++;
    if (adiff(int'(x_out), ex) > TOL || adiff(int'(y_out), ey) > TOL ||
        adiff(int'(z_out), ez) > TOL) begin
      n_fail++;
      $display("FAIL %s_result: x=%0d y=%0d z=%0d want %0d %0d %0d (+/-%0d)",
               nm, x_out, y_out, z_out, ex, ey, ez, TOL);
    end
    release_out();
  endtask

  task automatic test_rotation_zero();
    run_scenario("rot0", 1'b0, 10000, 0, 0, 16468, 0, 0);
  endtask

  task automatic test_rotation_90();
    run_scenario("rot90", 1'b0, 10000, 0, 102944, 0, 16468, 0);
  endtask

  task automatic test_vectoring();
    run_scenario("vec45", 1'b1, 10000, 10000, 0, 23289, 0, 51472);
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    int x0, y0, z0;
    bit bad;
    out_ready = 1'b0;
    start_op(1'b0, 10000, 0, 0, ok);
    wait_done(lat);
    n_checks++;
    if (lat !== ITERS || adiff(int'(x_out), 16468) > TOL) begin
      n_fail++;
      $display("FAIL bp_result: lat=%0d x=%0d want %0d 16468", lat, x_out, ITERS);
    end
    x0 = int'(x_out);
    y0 = int'(y_out);
    z0 = int'(z_out);
    bad = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'(x_out) != x0 ||
          int'(y_out) != y0 || int'(z_out) != z0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_hold: v=%b r=%b x=%0d y=%0d z=%0d want 1 0 %0d %0d %0d",
               out_valid, in_ready, x_out, y_out, z_out, x0, y0, z0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1",
               out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    start_op(1'b0, 10000, 0, 0, ok);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || x_out !== 0 ||
        y_out !== 0 || z_out !== 0) begin
      n_fail++;
      $display("FAIL midrst_clear: v=%b r=%b x=%0d y=%0d z=%0d want 0 0 0 0 0",
               out_valid, in_ready, x_out, y_out, z_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_ready: in_ready=%b want 1", in_ready);
    end
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL midrst_stale: out_valid seen=1 want 0");
    end
    run_scenario("midrst_rot0", 1'b0, 10000, 0, 0, 16468, 0, 0);
  endtask

  task automatic test_back_to_back();
    int acc_cyc[2];
    int rx[2], ry[2], rz[2];
    int n_acc;
    int n_res;
    bit acc;
    n_acc = 0;
    n_res = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    @(negedge clk);
    out_ready = 1'b1;
    mode      = 1'b0;
    x_in      = 16'sd10000;
    y_in      = 16'sd0;
    z_in      = '0;
    in_valid  = 1'b1;
    for (int c = 0; c < 200 && n_res < 2; c++) begin
      if (c != 0) @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        rx[n_res] = int'(x_out);
        ry[n_res] = int'(y_out);
        rz[n_res] = int'(z_out);
        n_res++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (n_acc < 2) acc_cyc[n_acc] = c;
        n_acc++;
        if (n_acc == 1) begin
          mode = 1'b1;
          x_in = 16'sd10000;
          y_in = 16'sd10000;
          z_in = '0;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (n_acc != 2 || n_res != 2) begin
      n_fail++;
      $display("FAIL b2b_counts: accepts=%0d results=%0d want 2 2", n_acc, n_res);
    end
    n_checks++;
    if (acc_cyc[1] - acc_cyc[0] != ITERS + 2) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d want %0d",
               acc_cyc[1] - acc_cyc[0], ITERS + 2);
    end
    if (n_res == 2) begin
      n_checks++;
      if (adiff(rx[0], 16468) > TOL || adiff(ry[0], 0) > TOL ||
          adiff(rz[0], 0) > TOL) begin
        n_fail++;
        $display("FAIL b2b_first: x=%0d y=%0d z=%0d want 16468 0 0",
                 rx[0], ry[0], rz[0]);
      end
      n_checks++;
      if (adiff(rx[1], 23289) > TOL || adiff(ry[1], 0) > TOL ||
          adiff(rz[1], 51472) > TOL) begin
        n_fail++;
        $display("FAIL b2b_second: x=%0d y=%0d z=%0d want 23289 0 51472",
                 rx[1], ry[1], rz[1]);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = 1'b0;
    x_in      = '0;
    y_in      = '0;
    z_in      = '0;
    test_reset();
    test_rotation_zero();
    test_rotation_90();
    test_vectoring();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
